mii_rx_deframer: RTL and testbench
==================================

// Module: mii_rx_deframer
// PURPOSE
//  Consumes the MAC-side MII RX nibble stream produced by the RMII PHY interface and delivers Ethernet frames as a byte stream.
//  Strips preamble/SFD and FCS, checks CRC-32, length, rxer and alignment, and keeps good/bad frame counters.
//  Runs entirely in the 50 MHz RMII reference clock domain, so rxc is treated as a data signal, not a clock.
//  Handles 10M and 100M modes transparently.
// PARAMETERS
//  MIN_LEN  64    minimum frame length in bytes, DA..FCS inclusive; shorter -> error
//  MAX_LEN  1518  maximum frame length in bytes, DA..FCS inclusive; longer -> error
//  CNT_W    16    width of the statistics counters
// PORTS
//  phy_rmii_ref_clk  in   1      50 MHz clock for all logic
//  rstn_async        in   1      asynchronous, active-low reset; asserted async, released via internal 2-flop sync
//  mii_rxc           in   1      MII RX clock generated in the same clock domain; no synchronizer
//  mii_rxdv          in   1      MII RX data valid
//  mii_rxer          in   1      MII RX error
//  mii_rxd           in   4      MII RX nibble
//  out_valid         out  1      one-cycle pulse per payload byte; no backpressure
//  out_data          out  8      payload byte, valid with out_valid
//  out_last          out  1      marks the final payload byte (FCS already removed)
//  out_err           out  1      frame status; valid only when out_last=1
//  frame_ok_cnt      out  CNT_W  good frames; wraps modulo 2^CNT_W
//  frame_err_cnt     out  CNT_W  bad frames that reached DATA state; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, FSM=WAIT, CRC=32'hFFFFFFFF, delay line empty. Reset mid-frame aborts the frame with no out_last.
//  Sampling: register mii_rxc once. A sample point is rxc_r=0 && mii_rxc=1 (rising edge).
//   At a sample point, rxdv/rxer/rxd are captured. Nothing else advances the datapath.
//  FSM (evaluated at sample points):
//   WAIT: rxdv=0 -> IDLE. Used after reset/abort so no frame is entered mid-stream.
//   IDLE: rxdv=1 && rxd=5 -> PRE. rxdv=1 && rxd!=5 -> WAIT.
//   PRE:  rxd=5 -> stay. rxd=D -> DATA (SFD = 0xD5, low nibble first).
//         Any other nibble, or rxdv=0 -> WAIT. No output, no counter change.
//   DATA: nibbles are low-first; the 2nd nibble completes a byte {hi,lo}.
//         rxdv=0 -> END (any half-byte nibble is discarded and sets the odd flag).
//   END:  one clock, not gated by a sample point; performs the flush, then -> IDLE.
//  Delay line: 5-entry byte shift register to strip the FCS.
//   When a byte completes and 5 entries are held, emit the oldest entry (out_valid=1, out_last=0) in the next clock.
//  END flush:
//   If bytes_total >= 5: emit entry[4] with out_last=1, discard the 4 FCS bytes.
//   If bytes_total < 5: emit nothing.
//   Either way, increment exactly one counter.
//  CRC: reflected poly 0xEDB88320, init FFFFFFFF, applied to every DATA byte including the FCS, no final XOR.
//   Good iff the register equals 32'hDEBB20E3 at END.
//  out_err = crc_bad | rxer_seen | odd_nibble | (bytes_total < MIN_LEN) | (bytes_total > MAX_LEN).
//   rxer_seen is sticky over DATA.
//   The byte counter is 11 bits and saturates at 2047; output continues past MAX_LEN.
//  Latency: a byte is emitted 5 completed bytes after its own completion. out_last comes 1 clock after END entry.
//  out_valid is a single-cycle pulse; beats are >=4 clocks apart at 100M and >=40 clocks apart at 10M.
//  frame_ok_cnt/frame_err_cnt update in the same clock as out_last, or in the END clock for runts.
// STRUCTURE
//  eth_defs.vh: CRC poly, residue 32'hDEBB20E3, PRE_NIB 4'h5, SFD_NIB 4'hD, FSM state encodings.
//   Shared with the future TX framer.
//  Sub-module eth_crc32_d8: combinational next-CRC(crc[31:0], byte[7:0]), reused by the TX side.
//  Top level holds the FSM, byte assembler, 5-deep delay line, length/flag logic and counters.
// TESTING
//  1. 100M (rxc period 2 clk): 7x0x55, 0xD5, 60 B payload, correct FCS
//     -> exactly 60 beats matching the payload; out_last on beat 60 with out_err=0; frame_ok_cnt=1.
//  2. Same frame, payload bit 0 of byte 10 flipped
//     -> 60 beats; out_last with out_err=1; frame_err_cnt=1, frame_ok_cnt unchanged.
//  3. 10M (rxc period 20 clk), frame from test 1
//     -> identical byte sequence; beat spacing 40 clk; out_err=0.
//  4. rxer high for one nibble at byte 20 -> out_err=1.
//     Separate frame with one extra nibble before rxdv drops -> out_err=1, still 60 beats.
//  5. Preamble nibble 0x3 injected -> no beats, counters unchanged.
//     4-byte frame -> no beats, frame_err_cnt+1.
//     1519-byte frame -> 1515 beats, out_err=1.
//  6. rstn_async low mid-frame -> all outputs 0 immediately, no out_last.
//     Released while rxdv=1 -> no beats until rxdv=0; next good frame decodes correctly.

Source files
------------

// File: rtl/mii_rx_deframer_pkg.sv
// Shared Ethernet RX/TX definitions: CRC constants, MII nibble codes,
// deframer FSM encoding and the captured MII nibble bundle.
package mii_rx_deframer_pkg;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    localparam logic [3:0] PRE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB = 4'hD;

    // Depth of the FCS-stripping delay line (4 FCS bytes + 1 held byte).
    localparam int DL_DEPTH = 5;

    typedef enum logic [2:0] {
        ST_WAIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_PRE  = 3'd2,
        ST_DATA = 3'd3,
        ST_END  = 3'd4
    } rx_state_t;

    typedef struct packed {
        logic       dv;
        logic       er;
        logic [3:0] d;
    } mii_nib_t;

endpackage

// File: rtl/mii_rx_deframer_crc32_d8.sv
// Combinational byte-wise CRC-32 step (reflected, poly 0xEDB88320).
// Ports: crc = current register, data = byte, nxt = updated register.
module mii_rx_deframer_crc32_d8
    import mii_rx_deframer_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] nxt
);

    always_comb begin : step
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = {1'b0, c[31:1]} ^ CRC_POLY;
            end else begin
                c = {1'b0, c[31:1]};
            end
        end
        nxt = c;
    end

endmodule

// File: rtl/mii_rx_deframer.sv
// MII RX deframer: strips preamble/SFD and FCS, checks CRC/length/rxer/
// alignment, emits payload bytes and keeps good/bad frame counters.
// Ports: phy_rmii_ref_clk/rstn_async clock and async reset; mii_rxc/
// mii_rxdv/mii_rxer/mii_rxd MII RX input; out_valid/out_data/out_last/
// out_err byte stream; frame_ok_cnt/frame_err_cnt statistics.
module mii_rx_deframer
    import mii_rx_deframer_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             phy_rmii_ref_clk,
    input  logic             rstn_async,
    input  logic             mii_rxc,
    input  logic             mii_rxdv,
    input  logic             mii_rxer,
    input  logic [3:0]       mii_rxd,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             out_err,
    output logic [CNT_W-1:0] frame_ok_cnt,
    output logic [CNT_W-1:0] frame_err_cnt
);

    localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
    localparam logic [10:0] CNT_SAT = 11'h7FF;
    localparam logic [2:0]  DL_FULL = 3'(DL_DEPTH);

    // Reset asserts asynchronously, releases after two clocks.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge phy_rmii_ref_clk or negedge rstn_async) begin
        if (!rstn_async) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // rxc is a data signal here; its rising edge marks a sample point.
    logic     rxc_r;
    logic     smp;
    mii_nib_t nib;

    assign smp = !rxc_r && mii_rxc;
    assign nib = {mii_rxdv, mii_rxer, mii_rxd};

    rx_state_t st, nxt_st;

    logic                      half;
    logic [3:0]                lo_nib;
    logic [7:0]                new_byte;
    logic [DL_DEPTH-1:0][7:0]  dl;
    logic [2:0]                dl_cnt;
    logic [31:0]               crc, crc_nxt;
    logic [10:0]               byte_cnt;
    logic                      rxer_seen;
    logic                      odd;
    logic                      frame_bad;

    logic start, take_lo, take_hi, stop, flush;

    assign new_byte = {nib.d, lo_nib};

    mii_rx_deframer_crc32_d8 u_crc (
        .crc  (crc),
        .data (new_byte),
        .nxt  (crc_nxt)
    );

    // State register
    always_ff @(posedge phy_rmii_ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= ST_WAIT;
            rxc_r <= 1'b0;
        end else begin
            st    <= nxt_st;
            rxc_r <= mii_rxc;
        end
    end

    // Next-state logic
    always_comb begin
        nxt_st = st;
        unique case (st)
            ST_WAIT: begin
                if (smp && !nib.dv) nxt_st = ST_IDLE;
            end
            ST_IDLE: begin
                if (smp && nib.dv) begin
                    nxt_st = (nib.d == PRE_NIB) ? ST_PRE : ST_WAIT;
                end
            end
            ST_PRE: begin
                if (smp) begin
                    if (!nib.dv) begin
                        nxt_st = ST_WAIT;
                    end else if (nib.d == PRE_NIB) begin
                        nxt_st = ST_PRE;
                    end else if (nib.d == SFD_NIB) begin
                        nxt_st = ST_DATA;
                    end else begin
                        nxt_st = ST_WAIT;
                    end
                end
            end
            ST_DATA: begin
                if (smp && !nib.dv) nxt_st = ST_END;
            end
            ST_END: begin
                nxt_st = ST_IDLE;
            end
            default: begin
                nxt_st = ST_WAIT;
            end
        endcase
    end

    // Control decode
    always_comb begin
        start   = 1'b0;
        take_lo = 1'b0;
        take_hi = 1'b0;
        stop    = 1'b0;
        flush   = 1'b0;
        unique case (st)
            ST_PRE: begin
                start = smp && nib.dv && (nib.d == SFD_NIB);
            end
            ST_DATA: begin
                take_lo = smp && nib.dv && !half;
                take_hi = smp && nib.dv && half;
                stop    = smp && !nib.dv;
            end
            ST_END: begin
                flush = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign frame_bad = (crc != CRC_RESIDUE) | rxer_seen | odd
                     | (byte_cnt < MIN_L) | (byte_cnt > MAX_L);

    // Datapath, delay line and counters
    always_ff @(posedge phy_rmii_ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            half          <= 1'b0;
            lo_nib        <= '0;
            dl            <= '0;
            dl_cnt        <= '0;
            crc           <= CRC_INIT;
            byte_cnt      <= '0;
            rxer_seen     <= 1'b0;
            odd           <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            out_err       <= 1'b0;
            frame_ok_cnt  <= '0;
            frame_err_cnt <= '0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;

            if (start) begin
                half      <= 1'b0;
                dl_cnt    <= '0;
                crc       <= CRC_INIT;
                byte_cnt  <= '0;
                rxer_seen <= 1'b0;
                odd       <= 1'b0;
            end

            if (take_lo) begin
                lo_nib    <= nib.d;
                half      <= 1'b1;
                rxer_seen <= rxer_seen | nib.er;
            end

            if (take_hi) begin
                half      <= 1'b0;
                rxer_seen <= rxer_seen | nib.er;
                crc       <= crc_nxt;
                dl        <= {dl[DL_DEPTH-2:0], new_byte};
                if (byte_cnt != CNT_SAT) byte_cnt <= byte_cnt + 11'd1;
                if (dl_cnt == DL_FULL) begin
                    out_valid <= 1'b1;
                    out_data  <= dl[DL_DEPTH-1];
                end else begin
                    dl_cnt <= dl_cnt + 3'd1;
                end
            end

            // A dangling low nibble when rxdv drops is an alignment error.
            if (stop) begin
                odd  <= odd | half;
                half <= 1'b0;
            end

            // Oldest held byte is the last payload byte; the rest is FCS.
            if (flush) begin
                if (byte_cnt >= 11'(DL_DEPTH)) begin
                    out_valid <= 1'b1;
                    out_last  <= 1'b1;
                    out_err   <= frame_bad;
                    out_data  <= dl[DL_DEPTH-1];
                end
                if (frame_bad) begin
                    frame_err_cnt <= frame_err_cnt + CNT_W'(1);
                end else begin
                    frame_ok_cnt  <= frame_ok_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Self-checking bench for mii_rx_deframer: scoreboard of expected payload
// bytes, per-scenario tasks checking beats, status and counters.
module tb_mii_rx_deframer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rxc = 1'b0;
    logic        rxdv = 1'b0;
    logic        rxer = 1'b0;
    logic [3:0]  rxd = 4'h0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_err;
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;

    mii_rx_deframer dut (
        .phy_rmii_ref_clk (clk),
        .rstn_async       (rstn),
        .mii_rxc          (rxc),
        .mii_rxdv         (rxdv),
        .mii_rxer         (rxer),
        .mii_rxd          (rxd),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_last         (out_last),
        .out_err          (out_err),
        .frame_ok_cnt     (ok_cnt),
        .frame_err_cnt    (err_cnt)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int half = 1;
    int exp_ok = 0;
    int exp_err = 0;

    logic [7:0] frm[$];
    logic [7:0] exp_q[$];

    int beat_cnt, last_cnt, last_at, min_gap, prev_cyc;
    logic last_err;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every beat is popped and compared against the queue.
    always @(negedge clk) begin
        if (out_valid) begin
            logic [7:0] e;
            beat_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL beat_unexpected got=%02h want=none", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    fails++;
                    $display("FAIL beat_data idx=%0d got=%02h want=%02h",
                             beat_cnt, out_data, e);
                end
            end
            if (out_last) begin
                last_cnt++;
                last_at = beat_cnt;
                last_err = out_err;
            end else begin
                if (prev_cyc >= 0 && (cyc - prev_cyc) < min_gap)
                    min_gap = cyc - prev_cyc;
                prev_cyc = cyc;
            end
        end
    end

    task automatic mon_clear();
        beat_cnt = 0;
        last_cnt = 0;
        last_at = 0;
        last_err = 1'b0;
        min_gap = 1000000;
        prev_cyc = -1;
    endtask

    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        logic fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frm[i][b];
                c = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic build(input int n);
        logic [31:0] f;
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
        f = fcs_of(n);
        for (int k = 0; k < 4; k++) frm.push_back(f[8*k +: 8]);
    endtask

    task automatic nib(input logic [3:0] d, input logic dv, input logic er);
        rxc = 1'b0;
        repeat (half) @(posedge clk);
        #1;
        rxc = 1'b1;
        rxd = d;
        rxdv = dv;
        rxer = er;
        repeat (half) @(posedge clk);
        #1;
    endtask

    task automatic send(input int er_byte, input bit extra,
                        input bit bad_pre, input bit push);
        if (push) begin
            for (int i = 0; i < frm.size() - 4; i++) exp_q.push_back(frm[i]);
        end
        nib(4'h0, 1'b0, 1'b0);
        nib(4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            nib((bad_pre && i == 6) ? 4'h3 : 4'h5, 1'b1, 1'b0);
        end
        nib(4'hD, 1'b1, 1'b0);
        for (int i = 0; i < frm.size(); i++) begin
            nib(frm[i][3:0], 1'b1, (i == er_byte));
            nib(frm[i][7:4], 1'b1, 1'b0);
        end
        if (extra) nib(4'hA, 1'b1, 1'b0);
        repeat (4) nib(4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({out_valid, out_last, out_err, out_data} !== 11'h0) begin
            fails++;
            $display("FAIL rst_outputs got=%03h want=000",
                     {out_valid, out_last, out_err, out_data});
        end
        tests++;
        if ({ok_cnt, err_cnt} !== 32'h0) begin
            fails++;
            $display("FAIL rst_counters got=%0d/%0d want=0/0", ok_cnt, err_cnt);
        end
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_good_100m();
        half = 1;
        build(60);
        mon_clear();
        send(-1, 1'b0, 1'b0, 1'b1);
        exp_ok++;
        tests++;
        if (beat_cnt !== 60 || last_cnt !== 1 || last_at !== 60) begin
            fails++;
            $display("FAIL t1_beats got=%0d/%0d/%0d want=60/1/60",
                     beat_cnt, last_cnt, last_at);
        end
        tests++;
        if (last_err !== 1'b0) begin
            fails++;
            $display("FAIL t1_err got=%b want=0", last_err);
        end
        tests++;
        if (ok_cnt !== 16'(exp_ok) || err_cnt !== 16'(exp_err)) begin
            fails++;
            $display("FAIL t1_cnt got=%0d/%0d want=%0d/%0d",
                     ok_cnt, err_cnt, exp_ok, exp_err);
        end
        tests++;
        if (min_gap !== 4) begin
            fails++;
            $display("FAIL t1_gap got=%0d want=4", min_gap);
        end
    endtask

    task automatic test_bad_crc();
        half = 1;
        frm[10][0] = ~frm[10][0];
        mon_clear();
        send(-1, 1'b0, 1'b0, 1'b1);
        frm[10][0] = ~frm[10][0];
        exp_err++;
        tests++;
        if (beat_cnt !== 60 || last_cnt !== 1 || last_err !== 1'b1) begin
            fails++;
            $display("FAIL t2_frame got=%0d/%0d/%b want=60/1/1",
                     beat_cnt, last_cnt, last_err);
        end
        tests++;
        if (ok_cnt !== 16'(exp_ok) || err_cnt !== 16'(exp_err)) begin
            fails++;
            $display("FAIL t2_cnt got=%0d/%0d want=%0d/%0d",
                     ok_cnt, err_cnt, exp_ok, exp_err);
        end
    endtask

    task automatic test_good_10m();
        half = 10;
        mon_clear();
        send(-1, 1'b0, 1'b0, 1'b1);
        exp_ok++;
        tests++;
        if (beat_cnt !== 60 || last_cnt !== 1 || last_err !== 1'b0) begin
            fails++;
            $display("FAIL t3_frame got=%0d/%0d/%b want=60/1/0",
                     beat_cnt, last_cnt, last_err);
        end
        tests++;
        if (min_gap !== 40) begin
            fails++;
            $display("FAIL t3_gap got=%0d want=40", min_gap);
        end
        tests++;
        if (ok_cnt !== 16'(exp_ok)) begin
            fails++;
            $display("FAIL t3_cnt got=%0d want=%0d", ok_cnt, exp_ok);
        end
        half = 1;
    endtask

    task automatic test_rxer_odd();
        build(60);
        mon_clear();
        send(20, 1'b0, 1'b0, 1'b1);
        exp_err++;
        tests++;
        if (beat_cnt !== 60 || last_err !== 1'b1) begin
            fails++;
            $display("FAIL t4_rxer got=%0d/%b want=60/1", beat_cnt, last_err);
        end
        mon_clear();
        send(-1, 1'b1, 1'b0, 1'b1);
        exp_err++;
        tests++;
        if (beat_cnt !== 60 || last_cnt !== 1 || last_err !== 1'b1) begin
            fails++;
            $display("FAIL t4_odd got=%0d/%0d/%b want=60/1/1",
                     beat_cnt, last_cnt, last_err);
        end
        tests++;
        if (ok_cnt !== 16'(exp_ok) || err_cnt !== 16'(exp_err)) begin
            fails++;
            $display("FAIL t4_cnt got=%0d/%0d want=%0d/%0d",
                     ok_cnt, err_cnt, exp_ok, exp_err);
        end
    endtask

    task automatic test_preamble_len();
        mon_clear();
        send(-1, 1'b0, 1'b1, 1'b0);
        tests++;
        if (beat_cnt !== 0 || ok_cnt !== 16'(exp_ok) || err_cnt !== 16'(exp_err)) begin
            fails++;
            $display("FAIL t5_pre got=%0d/%0d/%0d want=0/%0d/%0d",
                     beat_cnt, ok_cnt, err_cnt, exp_ok, exp_err);
        end
        build(0);
        mon_clear();
        send(-1, 1'b0, 1'b0, 1'b1);
        exp_err++;
        tests++;
        if (beat_cnt !== 0 || err_cnt !== 16'(exp_err)) begin
            fails++;
            $display("FAIL t5_runt got=%0d/%0d want=0/%0d",
                     beat_cnt, err_cnt, exp_err);
        end
        build(59);
        mon_clear();
        send(-1, 1'b0, 1'b0, 1'b1);
        exp_err++;
        tests++;
        if (beat_cnt !== 59 || last_err !== 1'b1 || err_cnt !== 16'(exp_err)) begin
            fails++;
            $display("FAIL t5_short got=%0d/%b/%0d want=59/1/%0d",
                     beat_cnt, last_err, err_cnt, exp_err);
        end
        build(1514);
        mon_clear();
        send(-1, 1'b0, 1'b0, 1'b1);
        exp_ok++;
        tests++;
        if (beat_cnt !== 1514 || last_err !== 1'b0 || ok_cnt !== 16'(exp_ok)) begin
            fails++;
            $display("FAIL t5_max got=%0d/%b/%0d want=1514/0/%0d",
                     beat_cnt, last_err, ok_cnt, exp_ok);
        end
        build(1515);
        mon_clear();
        send(-1, 1'b0, 1'b0, 1'b1);
        exp_err++;
        tests++;
        if (beat_cnt !== 1515 || last_cnt !== 1 || last_err !== 1'b1) begin
            fails++;
            $display("FAIL t5_long got=%0d/%0d/%b want=1515/1/1",
                     beat_cnt, last_cnt, last_err);
        end
        tests++;
        if (ok_cnt !== 16'(exp_ok) || err_cnt !== 16'(exp_err)) begin
            fails++;
            $display("FAIL t5_cnt got=%0d/%0d want=%0d/%0d",
                     ok_cnt, err_cnt, exp_ok, exp_err);
        end
    endtask

    task automatic test_reset_midframe();
        int snap;
        build(60);
        mon_clear();
        snap = 0;
        fork
            send(-1, 1'b0, 1'b0, 1'b1);
            begin
                repeat (200) @(posedge clk);
                #2;
                rstn = 1'b0;
                #1;
                tests++;
                if ({out_valid, out_last, out_err, out_data, ok_cnt, err_cnt} !== 43'h0) begin
                    fails++;
                    $display("FAIL t6_rst_out got=%b/%b/%b/%02h/%0d/%0d want=0",
                             out_valid, out_last, out_err, out_data, ok_cnt, err_cnt);
                end
                repeat (20) @(posedge clk);
                #1;
                rstn = 1'b1;
                snap = beat_cnt;
                tests++;
                if (rxdv !== 1'b1) begin
                    fails++;
                    $display("FAIL t6_release_dv got=%b want=1", rxdv);
                end
            end
        join
        tests++;
        if (beat_cnt !== snap || last_cnt !== 0 || snap == 0) begin
            fails++;
            $display("FAIL t6_abort got=%0d/%0d/%0d want=%0d/0/>0",
                     beat_cnt, last_cnt, snap, snap);
        end
        exp_q.delete();
        exp_ok = 0;
        exp_err = 0;
        build(60);
        mon_clear();
        send(-1, 1'b0, 1'b0, 1'b1);
        exp_ok++;
        tests++;
        if (beat_cnt !== 60 || last_cnt !== 1 || last_err !== 1'b0) begin
            fails++;
            $display("FAIL t6_next got=%0d/%0d/%b want=60/1/0",
                     beat_cnt, last_cnt, last_err);
        end
        tests++;
        if (ok_cnt !== 16'(exp_ok) || err_cnt !== 16'(exp_err)) begin
            fails++;
            $display("FAIL t6_cnt got=%0d/%0d want=%0d/%0d",
                     ok_cnt, err_cnt, exp_ok, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_good_100m();
        test_bad_crc();
        test_good_10m();
        test_rxer_odd();
        test_preamble_len();
        test_reset_midframe();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
